// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings and helpers for the hazard unit and its mult/div sequencer
package hazard_pkg;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_BUSY = 2'd1, MD_DONE = 2'd2} md_state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/hazard_unit_md_seq.sv
// md_seq: mult/div latency sequencer; done is a one-cycle HI/LO write strobe
module md_seq
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32,
  parameter int CNT_WIDTH   = 6
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  input  logic      is_div,
  output logic      busy,
  output logic      done,
  output md_state_t state
);
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] load;
  assign load = is_div ? CNT_WIDTH'(DIV_LATENCY - 1) : CNT_WIDTH'(MUL_LATENCY - 1);
  // start is only honoured from IDLE or DONE; a start while BUSY is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (state == MD_BUSY) begin
      if (cnt == '0) begin
        state <= MD_DONE;
        done  <= 1'b1;
      end else cnt <= cnt - 1'b1;
    end else if (start) begin
      state <= MD_BUSY;
      cnt   <= load;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= MD_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end
  end
endmodule

// File: rtl/hazard_unit_md.sv
// hazard_unit_md: forwarding, load-use/branch/JR/mult-div stalls for the 5-stage MIPS core
// Optional stall performance counters enabled by HAZARD_PERF_CNT_EN.
module hazard_unit_md
  import hazard_pkg::*;
#(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int MUL_LATENCY   = 4,
  parameter int DIV_LATENCY   = 32,
  parameter int CNT_WIDTH     = 6,
  parameter int PERF_WIDTH    = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_BranchD,
  input  logic                     i_JrD,
  input  logic                     i_JD,
  input  logic                     i_ALUSrcD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsE,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic                     i_RegWriteE,
  input  logic                     i_RegWriteM,
  input  logic                     i_RegWriteW,
  input  logic                     i_MemtoRegE,
  input  logic                     i_MemtoRegM,
  input  logic                     i_MdOpD,
  input  logic                     i_HiLoReadD,
  input  logic                     i_MdStartE,
  input  logic                     i_MdIsDivE,
  output logic                     o_StallF,
  output logic                     o_StallD,
  output logic                     o_FlushE,
  output logic                     o_ForwardAD,
  output logic                     o_ForwardBD,
  output logic [1:0]               o_ForwardAE,
  output logic [1:0]               o_ForwardBE,
  output logic                     o_MdBusy,
  output logic                     o_MdDone
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_WIDTH-1:0]    o_LwStallCnt,
  output logic [PERF_WIDTH-1:0]    o_BrStallCnt,
  output logic [PERF_WIDTH-1:0]    o_MdStallCnt
`endif
);
  md_state_t md_state;
  logic rs_nz, rt_nz, rs_e, rt_e, rs_m, rt_m;
  logic lwstall, branchstall, jrstall, mdstall, stall;
  md_seq #(
    .MUL_LATENCY(MUL_LATENCY),
    .DIV_LATENCY(DIV_LATENCY),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_md_seq (
    .clk   (i_clk),
    .rst   (i_rst),
    .start (i_MdStartE),
    .is_div(i_MdIsDivE),
    .busy  (o_MdBusy),
    .done  (o_MdDone),
    .state (md_state)
  );
  assign o_ForwardAE = (i_RsE != '0 && i_RegWriteM && i_RsE == i_WriteRegM) ? FWD_M :
                       (i_RsE != '0 && i_RegWriteW && i_RsE == i_WriteRegW) ? FWD_W : FWD_RF;
  assign o_ForwardBE = (i_RtE != '0 && i_RegWriteM && i_RtE == i_WriteRegM) ? FWD_M :
                       (i_RtE != '0 && i_RegWriteW && i_RtE == i_WriteRegW) ? FWD_W : FWD_RF;
  assign rs_nz = i_RsD != '0;
  assign rt_nz = i_RtD != '0;
  assign o_ForwardAD = i_RegWriteM && rs_nz && i_RsD == i_WriteRegM;
  assign o_ForwardBD = i_RegWriteM && rt_nz && i_RtD == i_WriteRegM;
  assign rs_e = rs_nz && i_RsD == i_WriteRegE;
  assign rt_e = rt_nz && i_RtD == i_WriteRegE;
  assign rs_m = rs_nz && i_RsD == i_WriteRegM;
  assign rt_m = rt_nz && i_RtD == i_WriteRegM;
  assign lwstall = i_MemtoRegE && !i_JD && ((rs_nz && i_RsD == i_RtE) ||
                   (rt_nz && i_RtD == i_RtE && !i_ALUSrcD && !i_JrD));
  assign branchstall = i_BranchD && ((i_RegWriteE && (rs_e || rt_e)) || (i_MemtoRegM && (rs_m || rt_m)));
  assign jrstall = i_JrD && ((i_RegWriteE && rs_e) || (i_MemtoRegM && rs_m));
  assign mdstall = (i_MdOpD || i_HiLoReadD) && (i_MdStartE || md_state != MD_IDLE);
  assign stall = lwstall || branchstall || jrstall || mdstall;
  assign o_StallF = stall;
  assign o_StallD = stall;
  assign o_FlushE = stall;
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_LwStallCnt <= '0;
      o_BrStallCnt <= '0;
      o_MdStallCnt <= '0;
    end else begin
      if (lwstall && !(&o_LwStallCnt)) o_LwStallCnt <= o_LwStallCnt + 1'b1;
      if ((branchstall || jrstall) && !(&o_BrStallCnt)) o_BrStallCnt <= o_BrStallCnt + 1'b1;
      if (mdstall && !(&o_MdStallCnt)) o_MdStallCnt <= o_MdStallCnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_unit_md.sv
// tb_hazard_unit_md: directed self-checking bench for hazard_unit_md
module tb_hazard_unit_md;
  logic clk = 1'b0, rst;
  logic i_BranchD, i_JrD, i_JD, i_ALUSrcD;
  logic [4:0] i_RsD, i_RtD, i_RsE, i_RtE, i_WriteRegE, i_WriteRegM, i_WriteRegW;
  logic i_RegWriteE, i_RegWriteM, i_RegWriteW, i_MemtoRegE, i_MemtoRegM;
  logic i_MdOpD, i_HiLoReadD, i_MdStartE, i_MdIsDivE;
  logic o_StallF, o_StallD, o_FlushE, o_ForwardAD, o_ForwardBD, o_MdBusy, o_MdDone;
  logic [1:0] o_ForwardAE, o_ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [3:0] o_LwStallCnt, o_BrStallCnt, o_MdStallCnt;
`endif
  int tests = 0, fails = 0;
  hazard_unit_md #(.PERF_WIDTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_BranchD(i_BranchD), .i_JrD(i_JrD), .i_JD(i_JD),
    .i_ALUSrcD(i_ALUSrcD), .i_RsD(i_RsD), .i_RtD(i_RtD), .i_RsE(i_RsE), .i_RtE(i_RtE),
    .i_WriteRegE(i_WriteRegE), .i_WriteRegM(i_WriteRegM), .i_WriteRegW(i_WriteRegW),
    .i_RegWriteE(i_RegWriteE), .i_RegWriteM(i_RegWriteM), .i_RegWriteW(i_RegWriteW),
    .i_MemtoRegE(i_MemtoRegE), .i_MemtoRegM(i_MemtoRegM), .i_MdOpD(i_MdOpD),
    .i_HiLoReadD(i_HiLoReadD), .i_MdStartE(i_MdStartE), .i_MdIsDivE(i_MdIsDivE),
    .o_StallF(o_StallF), .o_StallD(o_StallD), .o_FlushE(o_FlushE),
    .o_ForwardAD(o_ForwardAD), .o_ForwardBD(o_ForwardBD),
    .o_ForwardAE(o_ForwardAE), .o_ForwardBE(o_ForwardBE),
    .o_MdBusy(o_MdBusy), .o_MdDone(o_MdDone)
`ifdef HAZARD_PERF_CNT_EN
    , .o_LwStallCnt(o_LwStallCnt), .o_BrStallCnt(o_BrStallCnt), .o_MdStallCnt(o_MdStallCnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {i_BranchD, i_JrD, i_JD, i_ALUSrcD} = '0;
    {i_RsD, i_RtD, i_RsE, i_RtE, i_WriteRegE, i_WriteRegM, i_WriteRegW} = '0;
    {i_RegWriteE, i_RegWriteM, i_RegWriteW, i_MemtoRegE, i_MemtoRegM} = '0;
    {i_MdOpD, i_HiLoReadD, i_MdStartE, i_MdIsDivE} = '0;
  endtask
  task automatic test_reset();
    clr();
    rst = 1'b1;
    tick();
    tick();
    tests++; if (o_MdBusy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", o_MdBusy); end
    tests++; if (o_MdDone !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", o_MdDone); end
    tests++; if ({o_StallF, o_StallD, o_FlushE} !== 3'b000) begin fails++; $display("FAIL reset_stall got %b want 000", {o_StallF, o_StallD, o_FlushE}); end
    rst = 1'b0;
    tick();
  endtask
  task automatic test_forward();
    clr();
    i_RegWriteM = 1; i_WriteRegM = 8; i_RegWriteW = 1; i_WriteRegW = 8; i_RsE = 8; #1;
    tests++; if (o_ForwardAE !== 2'd2) begin fails++; $display("FAIL fwd_ae_m got %0d want 2", o_ForwardAE); end
    i_RsE = 0; #1;
    tests++; if (o_ForwardAE !== 2'd0) begin fails++; $display("FAIL fwd_ae_r0 got %0d want 0", o_ForwardAE); end
    i_RegWriteM = 0; i_RtE = 8; #1;
    tests++; if (o_ForwardBE !== 2'd1) begin fails++; $display("FAIL fwd_be_w got %0d want 1", o_ForwardBE); end
    i_RegWriteM = 1; i_RtD = 8; #1;
    tests++; if (o_ForwardBD !== 1'b1) begin fails++; $display("FAIL fwd_bd got %b want 1", o_ForwardBD); end
  endtask
  task automatic test_lwstall();
    clr();
    i_MemtoRegE = 1; i_RtE = 9; i_RsD = 9; #1;
    tests++; if ({o_StallF, o_StallD, o_FlushE} !== 3'b111) begin fails++; $display("FAIL lw_rs got %b want 111", {o_StallF, o_StallD, o_FlushE}); end
    tick();
    i_MemtoRegE = 0; #1;
    tests++; if (o_StallD !== 1'b0) begin fails++; $display("FAIL lw_release got %b want 0", o_StallD); end
    i_MemtoRegE = 1; i_JD = 1; #1;
    tests++; if (o_StallD !== 1'b0) begin fails++; $display("FAIL lw_jd got %b want 0", o_StallD); end
    i_JD = 0; i_RsD = 0; i_RtD = 9; i_ALUSrcD = 1; #1;
    tests++; if (o_StallD !== 1'b0) begin fails++; $display("FAIL lw_rt_imm got %b want 0", o_StallD); end
    i_ALUSrcD = 0; #1;
    tests++; if (o_StallD !== 1'b1) begin fails++; $display("FAIL lw_rt got %b want 1", o_StallD); end
  endtask
  task automatic test_branch();
    clr();
    i_BranchD = 1; i_RsD = 3; i_RegWriteE = 1; i_WriteRegE = 3; #1;
    tests++; if (o_StallD !== 1'b1) begin fails++; $display("FAIL br_e got %b want 1", o_StallD); end
    tick();
    i_RegWriteE = 0; i_WriteRegE = 0; i_RegWriteM = 1; i_WriteRegM = 3; #1;
    tests++; if (o_StallD !== 1'b0) begin fails++; $display("FAIL br_m_alu got %b want 0", o_StallD); end
    tests++; if (o_ForwardAD !== 1'b1) begin fails++; $display("FAIL br_fwd_ad got %b want 1", o_ForwardAD); end
    i_MemtoRegM = 1; #1;
    tests++; if (o_StallD !== 1'b1) begin fails++; $display("FAIL br_m_load got %b want 1", o_StallD); end
    clr();
    i_JrD = 1; i_RtD = 4; i_RegWriteE = 1; i_WriteRegE = 4; #1;
    tests++; if (o_StallD !== 1'b0) begin fails++; $display("FAIL jr_rt got %b want 0", o_StallD); end
    i_RsD = 4; #1;
    tests++; if (o_StallD !== 1'b1) begin fails++; $display("FAIL jr_rs got %b want 1", o_StallD); end
  endtask
  task automatic test_mult();
    clr();
    i_MdStartE = 1; i_HiLoReadD = 1; #1;
    tests++; if (o_StallD !== 1'b1) begin fails++; $display("FAIL mul_issue_stall got %b want 1", o_StallD); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      i_MdStartE = 0; #1;
      tests++; if (o_StallD !== (k <= 5)) begin fails++; $display("FAIL mul_stall c%0d got %b want %b", k, o_StallD, k <= 5); end
      tests++; if (o_MdDone !== (k == 5)) begin fails++; $display("FAIL mul_done c%0d got %b want %b", k, o_MdDone, k == 5); end
      tests++; if (o_MdBusy !== (k <= 5)) begin fails++; $display("FAIL mul_busy c%0d got %b want %b", k, o_MdBusy, k <= 5); end
    end
  endtask
  task automatic test_back_to_back();
    clr();
    i_MdStartE = 1; #1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      i_MdStartE = 0; #1;
      tests++; if (o_MdDone !== (k == 5)) begin fails++; $display("FAIL b2b_op1 c%0d got %b want %b", k, o_MdDone, k == 5); end
    end
    i_MdStartE = 1; #1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      i_MdStartE = (k == 2); i_MdIsDivE = (k == 2); #1;
      tests++; if (o_MdDone !== (k == 5) || o_MdBusy !== 1'b1) begin fails++; $display("FAIL b2b_op2 c%0d got done=%b busy=%b want done=%b busy=1", k, o_MdDone, o_MdBusy, k == 5); end
    end
    i_MdStartE = 0; i_MdIsDivE = 0;
    tick();
    tests++; if (o_MdBusy !== 1'b0) begin fails++; $display("FAIL b2b_idle got %b want 0", o_MdBusy); end
  endtask
  task automatic test_reset_abort();
    int pulses = 0, lat = 0;
    clr();
    i_MdStartE = 1; i_MdIsDivE = 1; #1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      i_MdStartE = 0; i_MdIsDivE = 0;
    end
    rst = 1;
    tick();
    rst = 0; #1;
    tests++; if (o_MdBusy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", o_MdBusy); end
    for (int k = 0; k < 40; k++) begin
      if (o_MdDone) pulses++;
      tick();
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL abort_done_pulses got %0d want 0", pulses); end
    i_MdStartE = 1; #1;
    while (lat < 20 && o_MdDone !== 1'b1) begin
      tick();
      i_MdStartE = 0; #1;
      lat++;
    end
    tests++; if (lat !== 5) begin fails++; $display("FAIL abort_fresh_mul latency got %0d want 5", lat); end
    tick();
  endtask
`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    clr();
    rst = 1;
    tick();
    rst = 0;
    i_MemtoRegE = 1; i_RtE = 9; i_RsD = 9;
    for (int k = 0; k < 20; k++) tick();
    tests++; if (o_LwStallCnt !== 4'd15) begin fails++; $display("FAIL perf_lw got %0d want 15", o_LwStallCnt); end
    tests++; if (o_BrStallCnt !== 4'd0 || o_MdStallCnt !== 4'd0) begin fails++; $display("FAIL perf_other got br=%0d md=%0d want 0 0", o_BrStallCnt, o_MdStallCnt); end
  endtask
`endif
  initial begin
    test_reset();
    test_forward();
    test_lwstall();
    test_branch();
    test_mult();
    test_back_to_back();
    test_reset_abort();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hazard_unit_md.md
Name: hazard_unit_md

Overview:
Next-generation pipeline hazard controller for the 5-stage MIPS core. It keeps the existing forwarding rules and the load-use, branch and JR stall/flush rules. It adds a sequencer for a multi-cycle mult/div unit with parametrised latencies, which stalls dependent HI/LO reads and back-to-back mult/div ops. Sits beside the control unit; drives the F/D enables, the E flush and the forwarding muxes, and issues the HI/LO write strobe.

Parameters:
RF_ADDR_WIDTH, 5, register-file address width
MUL_LATENCY, 4, cycles from mult issue in E to result ready (>=1)
DIV_LATENCY, 32, cycles from div issue in E to result ready (>=1)
CNT_WIDTH, 6, latency counter width; must hold max(MUL_LATENCY,DIV_LATENCY)-1
PERF_WIDTH, 32, performance counter width (optional feature only)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous active-high reset
i_BranchD, i_JrD, i_JD, i_ALUSrcD  in  1  decode control from the control unit
i_RsD, i_RtD, i_RsE, i_RtE  in  RF_ADDR_WIDTH  source register IDs in D and E
i_WriteRegE, i_WriteRegM, i_WriteRegW  in  RF_ADDR_WIDTH  destination register IDs
i_RegWriteE, i_RegWriteM, i_RegWriteW, i_MemtoRegE, i_MemtoRegM  in  1  pipeline control
i_MdOpD  in  1  mult/div instruction in D
i_HiLoReadD  in  1  mfhi/mflo in D
i_MdStartE  in  1  mult/div instruction in E (issue strobe)
i_MdIsDivE  in  1  1 = div, 0 = mult; valid with i_MdStartE
o_StallF, o_StallD, o_FlushE  out  1  stall/flush controls
o_ForwardAD, o_ForwardBD  out  1  branch/JR comparator forward select (1 = ALUOutM)
o_ForwardAE, o_ForwardBE  out  2  ALU forward select: 0 = RF, 1 = ResultW, 2 = ALUOutM
o_MdBusy  out  1  sequencer not idle
o_MdDone  out  1  one-cycle HI/LO write strobe

Behaviour:
- Forwarding (combinational). The M-stage match has priority over the W-stage match; register 0 never forwards. ForwardAD/BD is set when RegWriteM and a nonzero RsD/RtD equals WriteRegM.
- lwstall: MemtoRegE and either of:
  - nonzero RsD == RtE
  - nonzero RtD == RtE, with !ALUSrcD and !JrD
  Suppressed when JD.
- branchstall: BranchD and either of:
  - RegWriteE with a nonzero Rs/Rt match on WriteRegE
  - MemtoRegM with a nonzero Rs/Rt match on WriteRegM
- jrstall: same two cases as branchstall, Rs only, qualified by JrD.
- mdstall: (i_MdOpD | i_HiLoReadD) & (i_MdStartE | state != MD_IDLE).
- o_StallF = o_StallD = o_FlushE = lwstall | branchstall | jrstall | mdstall.
- Sequencer FSM, registered, 3 states:
  - MD_IDLE: on i_MdStartE, load cnt = (i_MdIsDivE ? DIV_LATENCY : MUL_LATENCY) - 1, go to MD_BUSY.
  - MD_BUSY: if cnt == 0 go to MD_DONE, else cnt -= 1.
  - MD_DONE: o_MdDone = 1 for this cycle (HI/LO written at its end). Next state MD_IDLE. If i_MdStartE is also set, reload cnt and go directly to MD_BUSY (back-to-back issue).
- Latency 1: IDLE -> BUSY (1 cycle) -> DONE.
- Total: issue cycle N gives o_MdDone in cycle N+LAT+1. A dependent mfhi in D stalls through the DONE cycle and reads new HI/LO in cycle N+LAT+2.
- i_MdStartE while in MD_BUSY is a protocol violation: ignored; no reload.
- o_MdBusy = (state != MD_IDLE).
- Reset: state MD_IDLE, cnt 0, o_MdDone 0, o_MdBusy 0; all combinational outputs follow their inputs. Reset mid-operation aborts with no Done pulse.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs o_LwStallCnt, o_BrStallCnt and o_MdStallCnt (each PERF_WIDTH).
  - Each counts cycles where its stall cause is active; jrstall counts in o_BrStallCnt.
  - Counters saturate at all-ones and clear on i_rst.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - forward-select encodings FWD_RF = 0, FWD_W = 1, FWD_M = 2
  - FSM state encodings MD_IDLE / MD_BUSY / MD_DONE
  - function clog2 for sizing CNT_WIDTH
- Sub-module md_seq: holds the FSM and counter. Inputs: clk, rst, start, is_div. Outputs: busy, done, state.
- Forwarding and stall logic stay in the top module.

Test Plan:
- RegWriteM = 1, WriteRegM = 8, RegWriteW = 1, WriteRegW = 8, RsE = 8 -> ForwardAE = 2; set RsE = 0 -> ForwardAE = 0.
- MemtoRegE = 1, RtE = 9, RsD = 9 -> StallF = StallD = FlushE = 1 for exactly one cycle; additionally JD = 1 -> no stall.
- BranchD = 1, RsD = 3, RegWriteE = 1, WriteRegE = 3 -> stall. Next cycle RegWriteM = 1, WriteRegM = 3, MemtoRegM = 0 -> no stall, ForwardAD = 1.
- MUL_LATENCY = 4: MdStartE at cycle 10, HiLoReadD held -> StallD = 1 in cycles 10-15, o_MdDone = 1 only in cycle 15, StallD = 0 in cycle 16.
- Div issued (DIV_LATENCY = 32), i_rst at cycle 5 of the op -> MdBusy = 0 next cycle, no o_MdDone pulse; a fresh mult then completes normally.
- With HAZARD_PERF_CNT_EN defined and PERF_WIDTH = 4: hold lwstall for 20 cycles -> o_LwStallCnt = 15 (saturated).
